// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM encodings and trap-cause constants for the PC generator
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } pc_state_t;

    // Value of the trap_cause MSB: interrupts vs synchronous exceptions
    localparam logic CAUSE_INT = 1'b1;
    localparam logic CAUSE_EXC = 1'b0;

endpackage

// File: rtl/irq_pend_arb.sv
// irq_pend_arb: per-channel rising-edge pending latches with lowest-index-wins arbitration
module irq_pend_arb #(
    parameter int NUM_IRQ = 4,
    parameter int IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] i_lvl,
    input  logic [NUM_IRQ-1:0] i_en,
    input  logic               i_take,
    output logic               o_valid,
    output logic [IW-1:0]      o_idx
);

    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_rise;

    assign w_elig = r_pend & i_en;
    assign w_rise = i_lvl & ~r_prev;
    assign w_clr  = i_take ? (NUM_IRQ'(1) << o_idx) : '0;

    // Lowest eligible channel wins; scan high to low so the last hit is the lowest
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                o_valid = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

    // A fresh edge in the take cycle re-arms the channel, so the set term wins over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= i_lvl;
            r_pend <= (r_pend & ~w_clr) | w_rise;
        end
    end

endmodule

// File: rtl/pc_gen_vec.sv
// pc_gen_vec: program counter generator with start FSM, traps and vectored interrupts
module pc_gen_vec
    import cpu_pkg::*;
#(
    parameter int AW      = 30,
    parameter int NUM_IRQ = 4,
    parameter int CW      = $clog2(NUM_IRQ) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_start,
    input  logic [AW-1:0]      cpu_start_adr,
    input  logic               cpu_stat_pc,
    input  logic [NUM_IRQ-1:0] irq_lvl,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               ecall_ex,
    input  logic               exc_ex,
    input  logic               xret_ex,
    input  logic               jmp_ex,
    input  logic [AW-1:0]      jmp_adr_ex,
    input  logic [AW-1:0]      csr_tvec_ex,
    input  logic               tvec_mode,
    input  logic [AW-1:0]      csr_epc_ex,
    output logic [AW-1:0]      pc,
    output logic [AW-1:0]      pc_epc,
    output logic               trap_taken,
    output logic [CW-1:0]      trap_cause
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    pc_state_t     r_state;
    pc_state_t     w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_step;
    logic [AW-1:0] w_irq_tgt;
    logic [CW-1:0] r_cause;
    logic [CW-1:0] w_cause_nxt;
    logic [CW-1:0] w_irq_cause;
    logic [IW-1:0] w_idx;
    logic          w_irq_valid;
    logic          w_exc;
    logic          w_adv;
    logic          w_take_irq;
    logic          w_trap;

    irq_pend_arb #(.NUM_IRQ(NUM_IRQ), .IW(IW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_lvl   (irq_lvl),
        .i_en    (irq_en),
        .i_take  (w_take_irq),
        .o_valid (w_irq_valid),
        .o_idx   (w_idx)
    );

    assign w_step      = r_pc + AW'(1);
    assign w_exc       = ecall_ex | exc_ex;
    assign w_irq_tgt   = tvec_mode ? csr_tvec_ex + AW'(w_idx) : csr_tvec_ex;
    assign w_irq_cause = CW'(w_idx) | (CW'(CAUSE_INT) << (CW - 1));
    assign w_adv       = (r_state == ST_RUN) && !cpu_start && cpu_stat_pc;
    assign w_trap      = w_adv && (w_exc || w_irq_valid);
    assign w_take_irq  = w_adv && !w_exc && w_irq_valid;

    // Next state, next pc and trap cause; a restart request in RUN beats the strobe
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cause_nxt = r_cause;
        if (r_state == ST_IDLE) begin
            w_state_nxt = cpu_start ? ST_ARMED : ST_IDLE;
        end else if (r_state == ST_ARMED) begin
            w_state_nxt = cpu_stat_pc ? ST_RUN : ST_ARMED;
            w_pc_nxt    = cpu_stat_pc ? cpu_start_adr : r_pc;
        end else if (cpu_start) begin
            w_state_nxt = ST_ARMED;
        end else if (cpu_stat_pc) begin
            w_pc_nxt    = w_exc       ? csr_tvec_ex :
                          w_irq_valid ? w_irq_tgt   :
                          xret_ex     ? csr_epc_ex  :
                          jmp_ex      ? jmp_adr_ex  : w_step;
            w_cause_nxt = w_exc       ? CW'(CAUSE_EXC) << (CW - 1) :
                          w_irq_valid ? w_irq_cause : r_cause;
        end
    end

    // State, pc and cause registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    assign pc         = r_pc;
    assign trap_taken = w_trap;
    assign trap_cause = r_cause;
    assign pc_epc     = ecall_ex ? w_step :
                        exc_ex   ? r_pc   :
                        jmp_ex   ? jmp_adr_ex : w_step;

endmodule

// File: tb/tb_pc_gen_vec.sv
// tb_pc_gen_vec: directed self-checking bench for the PC generator
module tb_pc_gen_vec;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_start;
    logic [29:0] cpu_start_adr;
    logic        cpu_stat_pc;
    logic [3:0]  irq_lvl;
    logic [3:0]  irq_en;
    logic        ecall_ex;
    logic        exc_ex;
    logic        xret_ex;
    logic        jmp_ex;
    logic [29:0] jmp_adr_ex;
    logic [29:0] csr_tvec_ex;
    logic        tvec_mode;
    logic [29:0] csr_epc_ex;
    logic [29:0] pc;
    logic [29:0] pc_epc;
    logic        trap_taken;
    logic [2:0]  trap_cause;

    int n_cmp = 0;
    int n_bad = 0;

    pc_gen_vec dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_start     (cpu_start),
        .cpu_start_adr (cpu_start_adr),
        .cpu_stat_pc   (cpu_stat_pc),
        .irq_lvl       (irq_lvl),
        .irq_en        (irq_en),
        .ecall_ex      (ecall_ex),
        .exc_ex        (exc_ex),
        .xret_ex       (xret_ex),
        .jmp_ex        (jmp_ex),
        .jmp_adr_ex    (jmp_adr_ex),
        .csr_tvec_ex   (csr_tvec_ex),
        .tvec_mode     (tvec_mode),
        .csr_epc_ex    (csr_epc_ex),
        .pc            (pc),
        .pc_epc        (pc_epc),
        .trap_taken    (trap_taken),
        .trap_cause    (trap_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_start = 1'b0; cpu_start_adr = '0; cpu_stat_pc = 1'b0;
        irq_lvl = '0; irq_en = 4'b1101; ecall_ex = 1'b0; exc_ex = 1'b0;
        xret_ex = 1'b0; jmp_ex = 1'b0; jmp_adr_ex = '0; csr_tvec_ex = 30'h40;
        tvec_mode = 1'b1; csr_epc_ex = '0;
        tick(); tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_cause", 32'(trap_cause), 32'h0);
        chk("rst_trap", 32'(trap_taken), 32'h0);
        rst = 1'b0;
        tick();
        cpu_start_adr = 30'h100; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        #1 chk("armed_hold", 32'(pc), 32'h0);
        cpu_stat_pc = 1'b1;
        tick();
        chk("start_load", 32'(pc), 32'h100);
        tick();
        chk("start_step", 32'(pc), 32'h101);
        tick(); tick(); tick(); tick();
        cpu_stat_pc = 1'b0;
        chk("pc_105", 32'(pc), 32'h105);
        irq_lvl[2] = 1'b1;
        tick();
        chk("irq2_nostrobe", 32'(trap_taken), 32'h0);
        chk("irq2_hold", 32'(pc), 32'h105);
        cpu_stat_pc = 1'b1;
        #1 chk("irq2_trap", 32'(trap_taken), 32'h1);
        chk("irq2_epc", 32'(pc_epc), 32'h106);
        tick();
        chk("irq2_pc", 32'(pc), 32'h42);
        chk("irq2_cause", 32'(trap_cause), 32'h6);
        chk("irq2_once", 32'(trap_taken), 32'h0);
        tick();
        chk("irq2_after", 32'(pc), 32'h43);
        cpu_stat_pc = 1'b0; irq_lvl[2] = 1'b0;
        jmp_ex = 1'b1; jmp_adr_ex = 30'h20; cpu_stat_pc = 1'b1;
        tick();
        chk("jmp_pc", 32'(pc), 32'h20);
        jmp_ex = 1'b0; cpu_stat_pc = 1'b0; irq_lvl[0] = 1'b1;
        tick();
        exc_ex = 1'b1; jmp_ex = 1'b1; jmp_adr_ex = 30'h77; cpu_stat_pc = 1'b1;
        #1 chk("prio_trap", 32'(trap_taken), 32'h1);
        chk("prio_epc", 32'(pc_epc), 32'h20);
        tick();
        chk("prio_pc", 32'(pc), 32'h40);
        chk("prio_cause", 32'(trap_cause), 32'h0);
        exc_ex = 1'b0; jmp_ex = 1'b0;
        #1 chk("irq0_pend", 32'(trap_taken), 32'h1);
        chk("irq0_epc", 32'(pc_epc), 32'h41);
        tick();
        chk("irq0_pc", 32'(pc), 32'h40);
        chk("irq0_cause", 32'(trap_cause), 32'h4);
        irq_lvl[0] = 1'b0;
        xret_ex = 1'b1; csr_epc_ex = 30'h200;
        tick();
        chk("xret_pc", 32'(pc), 32'h200);
        xret_ex = 1'b0; cpu_stat_pc = 1'b0; irq_lvl[1] = 1'b1;
        tick();
        cpu_stat_pc = 1'b1;
        #1 chk("mask_notrap", 32'(trap_taken), 32'h0);
        tick();
        chk("mask_pc", 32'(pc), 32'h201);
        irq_en = 4'b1111;
        #1 chk("unmask_trap", 32'(trap_taken), 32'h1);
        chk("unmask_epc", 32'(pc_epc), 32'h202);
        tick();
        chk("unmask_pc", 32'(pc), 32'h41);
        chk("unmask_cause", 32'(trap_cause), 32'h5);
        cpu_stat_pc = 1'b0; irq_lvl[1] = 1'b0; tvec_mode = 1'b0; irq_lvl[2] = 1'b1;
        tick();
        cpu_stat_pc = 1'b1;
        tick();
        chk("direct_pc", 32'(pc), 32'h40);
        chk("direct_cause", 32'(trap_cause), 32'h6);
        tvec_mode = 1'b1; irq_lvl[2] = 1'b0; ecall_ex = 1'b1;
        #1 chk("ecall_epc", 32'(pc_epc), 32'h41);
        tick();
        chk("ecall_pc", 32'(pc), 32'h40);
        chk("ecall_cause", 32'(trap_cause), 32'h0);
        ecall_ex = 1'b0; jmp_ex = 1'b1; jmp_adr_ex = 30'h3FFF_FFFF;
        tick();
        chk("ones_pc", 32'(pc), 32'h3FFF_FFFF);
        jmp_ex = 1'b0;
        tick();
        chk("wrap_pc", 32'(pc), 32'h0);
        cpu_stat_pc = 1'b0; irq_lvl[3] = 1'b1;
        tick();
        irq_lvl[3] = 1'b0;
        tick();
        irq_lvl[3] = 1'b1; cpu_stat_pc = 1'b1;
        #1 chk("irq3_trap1", 32'(trap_taken), 32'h1);
        chk("irq3_epc1", 32'(pc_epc), 32'h1);
        tick();
        chk("irq3_pc1", 32'(pc), 32'h43);
        chk("irq3_cause", 32'(trap_cause), 32'h7);
        chk("irq3_trap2", 32'(trap_taken), 32'h1);
        chk("irq3_epc2", 32'(pc_epc), 32'h44);
        tick();
        chk("irq3_pc2", 32'(pc), 32'h43);
        chk("irq3_done", 32'(trap_taken), 32'h0);
        tick();
        chk("irq3_step", 32'(pc), 32'h44);
        cpu_stat_pc = 1'b0; cpu_start = 1'b1; cpu_start_adr = 30'h300;
        tick();
        cpu_start = 1'b0;
        #1 chk("rearm_hold", 32'(pc), 32'h44);
        rst = 1'b1;
        #1 chk("async_pc", 32'(pc), 32'h0);
        chk("async_cause", 32'(trap_cause), 32'h0);
        cpu_stat_pc = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("idle_pc", 32'(pc), 32'h0);
        chk("idle_trap", 32'(trap_taken), 32'h0);
        cpu_stat_pc = 1'b0; cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0; cpu_stat_pc = 1'b1;
        tick();
        chk("restart_pc", 32'(pc), 32'h300);
        cpu_stat_pc = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen_vec.md
PC_GEN_VEC -- requirements
Module: pc_gen_vec

Interface
REQ-001 SHALL have parameter AW, default 30, meaning the word-address width of the PC (byte address [AW+1:2]).
REQ-002 SHALL have parameter NUM_IRQ, default 4, meaning the interrupt channel count (1..16).
REQ-003 SHALL have parameter CW, default $clog2(NUM_IRQ)+1, meaning the trap_cause width.
REQ-004 SHALL have ports, in this order:
  clk  in  1  clock
  rst  in  1  reset, asynchronous, active-high
  cpu_start  in  1  request to (re)load the start address
  cpu_start_adr  in  AW  start word address
  cpu_stat_pc  in  1  PC-advance strobe
  irq_lvl  in  NUM_IRQ  level interrupt sources
  irq_en  in  NUM_IRQ  per-channel enable
  ecall_ex  in  1  ecall in EX
  exc_ex  in  1  synchronous exception in EX
  xret_ex  in  1  trap return in EX
  jmp_ex  in  1  taken branch/jump in EX
  jmp_adr_ex  in  AW  jump target
  csr_tvec_ex  in  AW  trap vector base
  tvec_mode  in  1  1 = vectored interrupts
  csr_epc_ex  in  AW  return address
  pc  out  AW  current PC
  pc_epc  out  AW  EPC value to record
  trap_taken  out  1  one-cycle trap pulse
  trap_cause  out  CW  MSB 1 = interrupt, LSBs = channel or 0

Function
REQ-005 SHALL implement the FSM IDLE -> ARMED on cpu_start; ARMED -> RUN on cpu_stat_pc, loading pc <= cpu_start_adr; RUN -> ARMED on cpu_start.
REQ-006 SHALL hold pc in IDLE and ARMED, and SHALL change pc in RUN only in cycles where cpu_stat_pc=1.
REQ-007 SHALL select the next pc in RUN, in priority order: ecall_ex|exc_ex -> csr_tvec_ex; pending interrupt -> interrupt target; xret_ex -> csr_epc_ex; jmp_ex -> jmp_adr_ex; else pc+1.
REQ-008 SHALL form every pc+1 and base+index addition modulo 2^AW, so all-ones wraps to 0.
REQ-009 SHALL keep one pending latch per channel; the latch sets on a rising edge of irq_lvl[i] (registered previous level) and clears when channel i is taken.
REQ-010 SHALL keep a pending latch set when a new edge and a take of the same channel occur in the same cycle.
REQ-011 SHALL treat a channel as eligible only when it is pending and irq_en[i]=1, and the lowest eligible index SHALL win; masked channels keep their pending state.
REQ-012 SHALL use interrupt target csr_tvec_ex + i when tvec_mode=1, and csr_tvec_ex otherwise; exceptions always use csr_tvec_ex.
REQ-013 SHALL drive pc_epc combinationally: ecall -> pc+1; exc -> pc; interrupt -> jmp_adr_ex if jmp_ex else pc+1.
REQ-014 SHALL pulse trap_taken for exactly the cpu_stat_pc cycle in which a trap is taken in RUN.
REQ-015 SHALL drive trap_cause as {1'b1, i} for interrupts and 0 for ecall/exc; trap_cause SHALL hold its last value otherwise.
REQ-016 SHALL capture interrupt edges, but not take them, while in IDLE or ARMED.

Reset
REQ-017 SHALL asynchronously set, on rst=1: state IDLE, pc=0, pending=0, previous levels=0, trap_taken=0, trap_cause=0.
REQ-018 SHALL discard an in-flight load or trap when rst is asserted mid-operation; operation resumes only after a fresh cpu_start.

Structure
REQ-019 SHALL place FSM state encodings and cause-MSB constants in shared package cpu_pkg.
REQ-020 SHALL implement the interrupt latch and priority logic in sub-module irq_pend_arb, parameterised by NUM_IRQ.

Verification
REQ-021 SHALL cover start: cpu_start, cpu_start_adr=0x100, then cpu_stat_pc -> pc=0x100; next strobe -> 0x101.
REQ-022 SHALL cover vectored interrupt: tvec=0x40, tvec_mode=1, irq_lvl[2] rises, pc=0x105, strobe -> pc=0x42, pc_epc=0x106, trap_cause=0b110, trap_taken pulses once.
REQ-023 SHALL cover priority: exc_ex, irq0 pending, and jmp_ex together at pc=0x20 -> pc=tvec, pc_epc=0x20, cause=0, irq0 still pending.
REQ-024 SHALL cover masking: irq1 edge with irq_en[1]=0 -> no trap; set irq_en[1]=1 -> trap to tvec+1 at the next strobe.
REQ-025 SHALL cover wrap: pc=all-ones plus strobe -> pc=0; a second edge on irq3 in the cycle irq3 is taken -> irq3 is taken again on the following strobe.
REQ-026 SHALL cover reset during ARMED: assert rst -> pc=0, state IDLE; a cpu_stat_pc with no cpu_start leaves pc at 0.
